// File: rtl/ysyx_25020037_ifu.sv
// Instruction fetch unit: one AXI4-Lite read per instruction, then a
// valid/ready hand-off of {pc, inst} to the decoder. Faults park it in HALT.
module ysyx_25020037_ifu #(
    parameter logic [31:0] RESET_PC    = 32'h3000_0000,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        npc_valid,
    input  logic [31:0] npc,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        ifu_rvalid,
    input  logic        idu_ready,
    output logic        fetch_err,
    output logic [31:0] fetch_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        DELIVER,
        WAIT,
        HALT
    } state_t;

    state_t        state;
    logic [TW-1:0] tcnt;
    logic [31:0]   npc_buf;
    logic          npc_pend;
    logic          take;
    logic [31:0]   tgt;

    // A fresh redirect in WAIT wins over an older latched one.
    assign take   = npc_valid | npc_pend;
    assign tgt    = npc_valid ? npc : npc_buf;
    assign araddr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            inst       <= 32'h0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            ifu_rvalid <= 1'b0;
            fetch_err  <= 1'b0;
            fetch_cnt  <= 32'h0;
            npc_pend   <= 1'b0;
            npc_buf    <= 32'h0;
            tcnt       <= '0;
        end else begin
            if (npc_valid && state != WAIT) begin
                npc_buf  <= npc;
                npc_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    state   <= AR;
                    arvalid <= 1'b1;
                    tcnt    <= '0;
                end
                AR: begin
                    tcnt <= tcnt + 1'b1;
                    if (tcnt == TMAX) begin
                        fetch_err <= 1'b1;
                        arvalid   <= 1'b0;
                        state     <= HALT;
                    end else if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R;
                    end
                end
                R: begin
                    tcnt <= tcnt + 1'b1;
                    if (rvalid) begin
                        rready <= 1'b0;
                        if (rresp == 2'b00) begin
                            inst       <= rdata;
                            ifu_rvalid <= 1'b1;
                            state      <= DELIVER;
                        end else begin
                            fetch_err <= 1'b1;
                            state     <= HALT;
                        end
                    end else if (tcnt == TMAX) begin
                        fetch_err <= 1'b1;
                        rready    <= 1'b0;
                        state     <= HALT;
                    end
                end
                DELIVER: begin
                    if (idu_ready) begin
                        ifu_rvalid <= 1'b0;
                        fetch_cnt  <= fetch_cnt + 32'd1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (take) begin
                        npc_pend <= 1'b0;
                        if (tgt[1:0] != 2'b00) begin
                            fetch_err <= 1'b1;
                            state     <= HALT;
                        end else begin
                            pc      <= tgt;
                            arvalid <= 1'b1;
                            tcnt    <= '0;
                            state   <= AR;
                        end
                    end
                end
                HALT: begin
                    arvalid    <= 1'b0;
                    rready     <= 1'b0;
                    ifu_rvalid <= 1'b0;
                end
                default: state <= HALT;
            endcase
        end
    end

endmodule
